rc4_ksa: RTL
============

// Module: rc4_ksa
// PURPOSE
//  RC4 key-scheduling stage. Optionally fills S[i]=i, then runs 256 KSA iterations:
//  j = j + S[i] + key[i mod KEY_BYTES], then swap S[i], S[j].
//  Sits directly upstream of the PRGA/decrypt stage and shares its S-RAM port via the top-level mux.
//  Its done output drives the PRGA start input.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes (1..32)
//  RD_LAT     2  S-RAM read latency: cycles from address drive to s_q valid (1..4)
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               synchronous, active-high
//  start      in   1               level; sampled in IDLE only
//  key        in   KEY_BYTES*8     key; byte 0 = key[KEY_BYTES*8-1 -: 8] (MSB first)
//  s_q        in   8               S-RAM read data
//  s_address  out  8               S-RAM address
//  s_data     out  8               S-RAM write data
//  s_wren     out  1               S-RAM write enable
//  busy       out  1               high from start acceptance until done
//  done       out  1               level; high when S holds the scheduled permutation
// BEHAVIOUR
//  - Reset: all outputs 0, i=j=0, state IDLE. Reset mid-run aborts on the next edge; S contents are undefined.
//  - IDLE: if start=1 and done=0: latch key into key_r, i<=0, j<=0, busy<=1,
//    go to FILL (when RC4_INIT_FILL_EN) or RD_I. start held high after done causes no rerun.
//    start falling then rising clears done and reruns.
//  - FILL: s_wren=1, s_address=s_data=i, one byte per cycle. At i==255: i<=0, go to RD_I.
//  - RD_I: s_wren=0, s_address=i -> WT_I.
//  - WT_I: hold for RD_LAT cycles; on the last cycle si<=s_q -> CALC_J.
//  - CALC_J: j <= j + si + key_r byte (i mod KEY_BYTES); all arithmetic 8-bit modulo 256 -> RD_J.
//  - RD_J: s_address=j -> WT_J (RD_LAT cycles, sj<=s_q on last) -> WR_J.
//  - WR_J: s_wren=1, s_address=j, s_data=si -> WR_I.
//  - WR_I: s_wren=1, s_address=i, s_data=sj -> NEXT. If i==j, both writes target one address.
//    The second write (sj) equals si, so S is unchanged.
//  - NEXT: s_wren=0. If i==255: done<=1, busy<=0 -> DONE. Else i<=i+1 -> RD_I.
//    i must not wrap to 0 without terminating.
//  - DONE: outputs idle (s_wren=0). done stays high until reset or a start falling edge,
//    then return to IDLE.
//  - Per iteration: 6+2*RD_LAT cycles. Total: 256*(6+2*RD_LAT) (+256 with fill) + 2 handshake cycles.
//  - s_wren is never high except in FILL/WR_J/WR_I. key_r is immune to key changes while busy.
// CONFIGURATION
//  RC4_INIT_FILL_EN defined: FILL phase included; the block alone builds S from any RAM contents.
//  Undefined: no FILL state; S must already hold identity (separate init stage), and the run starts at RD_I.
// STRUCTURE
//  - rc4_pkg: ksa_state_t enum, S_SIZE=256, S_LAST=8'd255, byte-width typedefs shared with PRGA/init stages.
//  - Sub-module rc4_key_byte_sel: combinational key_r/i -> key byte (i mod KEY_BYTES via a wrapping
//    index counter, not a divider). Counter resets with i and wraps at KEY_BYTES-1.
//  - Remainder is a single FSM plus datapath registers; no other hierarchy.
// TESTING
//  1. Key 24'h000000, fill on -> S equals software KSA model for the all-zero key;
//     done=1, busy=0 at expected cycle count.
//  2. KEY_BYTES=3, key 24'h4B6579 ("Key") -> S matches model. Chained to PRGA, first keystream byte = 8'hEB.
//  3. Force i==j iteration (key giving j==i at i=0, e.g. key byte0 = 8'h00 with S[0]=0)
//     -> S[0] unchanged, two writes observed.
//  4. Reset asserted mid-WT_J -> next cycle all outputs 0, state IDLE. Restart completes correctly.
//  5. start held high across done -> no second run, no s_wren after done.
//     Toggle start low->high -> done clears within 1 cycle and run repeats.
//  6. Change key during run -> result equals model for the key latched at start. Repeat for RD_LAT=1 and 4.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants used by the KSA, PRGA and init stages.
package rc4_pkg;

  localparam int S_SIZE = 256;
  localparam logic [7:0] S_LAST = 8'd255;
  localparam int KIDX_W = 5;

  typedef logic [7:0] rc4_byte_t;

  typedef enum logic [3:0] {
    KSA_IDLE,
`ifdef RC4_INIT_FILL_EN
    KSA_FILL,
`endif
    KSA_RD_I,
    KSA_WT_I,
    KSA_CALC_J,
    KSA_RD_J,
    KSA_WT_J,
    KSA_WR_J,
    KSA_WR_I,
    KSA_NEXT,
    KSA_DONE
  } ksa_state_t;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Selects key byte number kidx_i from the latched key, byte 0 being the most significant.
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic [KEY_BYTES*8-1:0] key_i,
  input  logic [KIDX_W-1:0]      kidx_i,
  output logic [7:0]             key_byte_o
);

  always_comb begin
    key_byte_o = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_i == KIDX_W'(b)) key_byte_o = key_i[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

endmodule

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage driving the shared S-RAM port.
// Define RC4_INIT_FILL_EN to include the identity-fill phase ahead of the 256 KSA iterations.
module rc4_ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0]        WT_LAST   = 2'(RD_LAT - 1);
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  ksa_state_t             state_q, state_d;
  rc4_byte_t              i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [1:0]             wt_q, wt_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic                   busy_q, busy_d, done_q, done_d, start_q;
  rc4_byte_t              key_byte;

  // kidx tracks i mod KEY_BYTES so no divider is needed
  rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_byte_sel (
    .key_i      (key_q),
    .kidx_i     (kidx_q),
    .key_byte_o (key_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= KSA_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      wt_q    <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      wt_q    <= wt_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    kidx_d    = kidx_q;
    wt_d      = wt_q;
    key_d     = key_q;
    busy_d    = busy_q;
    done_d    = done_q;
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;

    case (state_q)
      KSA_IDLE: begin
        if (start && !done_q) begin
          key_d  = key;
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
          wt_d   = '0;
          busy_d = 1'b1;
`ifdef RC4_INIT_FILL_EN
          state_d = KSA_FILL;
`else
          state_d = KSA_RD_I;
`endif
        end
      end
`ifdef RC4_INIT_FILL_EN
      KSA_FILL: begin
        s_wren    = 1'b1;
        s_address = i_q;
        s_data    = i_q;
        if (i_q == S_LAST) begin
          i_d     = '0;
          state_d = KSA_RD_I;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
`endif
      KSA_RD_I: begin
        s_address = i_q;
        wt_d      = '0;
        state_d   = KSA_WT_I;
      end
      // Address is held for the whole wait so any RAM sampling point works
      KSA_WT_I: begin
        s_address = i_q;
        if (wt_q == WT_LAST) begin
          si_d    = s_q;
          state_d = KSA_CALC_J;
        end else begin
          wt_d = wt_q + 2'd1;
        end
      end
      KSA_CALC_J: begin
        j_d     = j_q + si_q + key_byte;
        state_d = KSA_RD_J;
      end
      KSA_RD_J: begin
        s_address = j_q;
        wt_d      = '0;
        state_d   = KSA_WT_J;
      end
      KSA_WT_J: begin
        s_address = j_q;
        if (wt_q == WT_LAST) begin
          sj_d    = s_q;
          state_d = KSA_WR_J;
        end else begin
          wt_d = wt_q + 2'd1;
        end
      end
      KSA_WR_J: begin
        s_wren    = 1'b1;
        s_address = j_q;
        s_data    = si_q;
        state_d   = KSA_WR_I;
      end
      // When i==j this rewrites the same byte with the same value
      KSA_WR_I: begin
        s_wren    = 1'b1;
        s_address = i_q;
        s_data    = sj_q;
        state_d   = KSA_NEXT;
      end
      KSA_NEXT: begin
        if (i_q == S_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = KSA_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
          state_d = KSA_RD_I;
        end
      end
      KSA_DONE: begin
        if (start_q && !start) begin
          done_d  = 1'b0;
          state_d = KSA_IDLE;
        end
      end
      default: state_d = KSA_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
